// File: rtl/apb_fsm_controller_if.sv
// ----------------------------------------------------------------------------
// apb_fsm_controller_if
//   Bundles the signals between the AHB slave interface, the APB sequencer and
//   the APB peripherals of the AHB-to-APB bridge.
//
//   AHB side (decoded pipeline info into the sequencer):
//     valid, Hwritereg, tempselx, Haddr1, Haddr2, Hwdata1 -> sequencer
//     Hreadyout                                           <- sequencer
//   APB side:
//     Pready                                              -> sequencer
//     Pselx, Penable, Pwrite, Paddr, Pwdata               <- sequencer
//
//   modport master : the sequencer view (drives APB outputs and Hreadyout)
//   modport slave  : the environment view (drives AHB info and Pready)
// ----------------------------------------------------------------------------
interface apb_fsm_controller_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NSLV   = 3
);
    logic              valid;
    logic              Hwritereg;
    logic [NSLV-1:0]   tempselx;
    logic [ADDR_W-1:0] Haddr1;
    logic [ADDR_W-1:0] Haddr2;
    logic [DATA_W-1:0] Hwdata1;
    logic              Pready;
    logic [NSLV-1:0]   Pselx;
    logic              Penable;
    logic              Pwrite;
    logic [ADDR_W-1:0] Paddr;
    logic [DATA_W-1:0] Pwdata;
    logic              Hreadyout;

    modport master (
        input  valid, Hwritereg, tempselx, Haddr1, Haddr2, Hwdata1, Pready,
        output Pselx, Penable, Pwrite, Paddr, Pwdata, Hreadyout
    );

    modport slave (
        output valid, Hwritereg, tempselx, Haddr1, Haddr2, Hwdata1, Pready,
        input  Pselx, Penable, Pwrite, Paddr, Pwdata, Hreadyout
    );
endinterface

// File: rtl/apb_fsm_controller.sv
// ----------------------------------------------------------------------------
// apb_fsm_controller
//   APB-side sequencer of the AHB-to-APB bridge. Takes the pipelined AHB
//   address/data-phase info and runs the APB SETUP/ACCESS handshake to one of
//   NSLV peripherals, stalling the AHB master through Hreadyout until the APB
//   transfer completes.
//
//   Ports:
//     Hclk     in  bridge clock, rising edge
//     Hresetn  in  asynchronous active-low reset
//     bus      apb_fsm_controller_if.master
//              in : valid, Hwritereg, tempselx, Haddr1, Haddr2, Hwdata1, Pready
//              out: Pselx, Penable, Pwrite, Paddr, Pwdata (registered),
//                   Hreadyout (combinational from state and Pready)
// ----------------------------------------------------------------------------
module apb_fsm_controller #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NSLV   = 3
) (
    input  logic                 Hclk,
    input  logic                 Hresetn,
    apb_fsm_controller_if.master bus
);

    typedef enum logic [2:0] {
        StIdle,
        StRwait,
        StWwait1,
        StWwait2,
        StSetup,
        StAccess
    } state_e;

    state_e state_q, state_d;

    logic [NSLV-1:0]   sel_q, sel_d;
    logic [NSLV-1:0]   pselx_q, pselx_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;

    logic hreadyout;
    logic accept;

    // A new AHB transfer is taken whenever the bridge is ready, including the
    // completing ACCESS cycle, so back-to-back transfers see no IDLE bubble.
    assign hreadyout = (state_q == StIdle) | ((state_q == StAccess) & bus.Pready);
    assign accept    = bus.valid & hreadyout;

    // State and registered outputs
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q   <= StIdle;
            sel_q     <= '0;
            pselx_q   <= '0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            pselx_q   <= pselx_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = bus.Hwritereg ? StWwait1 : StRwait;
                end
            end
            StRwait:  state_d = StSetup;
            StWwait1: state_d = StWwait2;
            StWwait2: state_d = StSetup;
            StSetup:  state_d = StAccess;
            StAccess: begin
                if (bus.Pready) begin
                    if (accept) begin
                        state_d = bus.Hwritereg ? StWwait1 : StRwait;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default:  state_d = StIdle;
        endcase
    end

    // Next values of the registered APB outputs
    always_comb begin
        sel_d     = accept ? bus.tempselx : sel_q;
        pselx_d   = pselx_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        case (state_q)
            StRwait: begin
                // Read address is one cycle old here
                paddr_d   = bus.Haddr1;
                pwrite_d  = 1'b0;
                pselx_d   = sel_q;
                penable_d = 1'b0;
            end
            StWwait2: begin
                // Write data trails its address by one cycle, so take the
                // two-cycle-old address alongside the one-cycle-old data
                paddr_d   = bus.Haddr2;
                pwdata_d  = bus.Hwdata1;
                pwrite_d  = 1'b1;
                pselx_d   = sel_q;
                penable_d = 1'b0;
            end
            StSetup: begin
                penable_d = 1'b1;
            end
            StAccess: begin
                if (bus.Pready) begin
                    pselx_d   = '0;
                    penable_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign bus.Pselx     = pselx_q;
    assign bus.Penable   = penable_q;
    assign bus.Pwrite    = pwrite_q;
    assign bus.Paddr     = paddr_q;
    assign bus.Pwdata    = pwdata_q;
    assign bus.Hreadyout = hreadyout;

endmodule

// File: tb/tb_apb_fsm_controller.sv
// ----------------------------------------------------------------------------
// tb_apb_fsm_controller
//   Directed bench for the APB sequencer. Expected transfers are queued when
//   the AHB side issues them and popped when a completing ACCESS cycle is seen.
// ----------------------------------------------------------------------------
module tb_apb_fsm_controller;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned NSLV   = 3;

    typedef struct packed {
        logic              wr;
        logic [NSLV-1:0]   sel;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } xfer_t;

    logic Hclk;
    logic Hresetn;
    logic [ADDR_W-1:0] haddr;
    logic [DATA_W-1:0] hwdata;

    int compares = 0;
    int fails    = 0;
    xfer_t exp_q[$];

    apb_fsm_controller_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NSLV(NSLV)) bus ();

    apb_fsm_controller #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NSLV(NSLV)) dut (
        .Hclk    (Hclk),
        .Hresetn (Hresetn),
        .bus     (bus)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    // AHB slave interface pipeline: address and data delayed by Hclk
    always @(posedge Hclk) begin
        bus.Haddr1  <= haddr;
        bus.Haddr2  <= bus.Haddr1;
        bus.Hwdata1 <= hwdata;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compares++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Per-cycle invariants plus scoreboard pop on a completing ACCESS
    task automatic sb_sample();
        xfer_t e;
        if (Hresetn !== 1'b1) return;
        chk("pselx_onehot0", 64'($onehot0(bus.Pselx)), 64'(1));
        chk("penable_has_sel", 64'(bus.Penable & (bus.Pselx == '0)), 64'(0));
        if ((bus.Pselx != '0) && bus.Penable && bus.Pready) begin
            chk("sb_expected_pending", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_pwrite", 64'(bus.Pwrite), 64'(e.wr));
                chk("sb_pselx", 64'(bus.Pselx), 64'(e.sel));
                chk("sb_paddr", 64'(bus.Paddr), 64'(e.addr));
                if (e.wr) chk("sb_pwdata", 64'(bus.Pwdata), 64'(e.data));
            end
        end
    endtask

    // Advance to just after the next rising edge
    task automatic cyc();
        sb_sample();
        @(posedge Hclk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [NSLV-1:0] sel,
                         input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        bus.valid     = 1'b1;
        bus.Hwritereg = wr;
        bus.tempselx  = sel;
        haddr         = addr;
        exp_q.push_back('{wr: wr, sel: sel, addr: addr, data: data});
    endtask

    task automatic idle_in();
        bus.valid     = 1'b0;
        bus.Hwritereg = 1'b0;
        bus.tempselx  = '0;
        haddr         = '0;
    endtask

    initial begin
        Hresetn    = 1'b0;
        hwdata     = '0;
        bus.Pready = 1'b1;
        idle_in();
        cyc();
        cyc();
        #1;
        chk("rst_pselx", 64'(bus.Pselx), 64'(0));
        chk("rst_penable", 64'(bus.Penable), 64'(0));
        chk("rst_pwrite", 64'(bus.Pwrite), 64'(0));
        chk("rst_paddr", 64'(bus.Paddr), 64'(0));
        chk("rst_pwdata", 64'(bus.Pwdata), 64'(0));
        chk("rst_hreadyout", 64'(bus.Hreadyout), 64'(1));
        cyc(); Hresetn = 1'b1;
        cyc(); #1;
        chk("idle_hreadyout", 64'(bus.Hreadyout), 64'(1));

        // Single read
        cyc(); issue(1'b0, 3'b001, 32'h8000_0010, '0); #1;
        chk("rd_T0_hready", 64'(bus.Hreadyout), 64'(1));
        cyc(); idle_in(); #1;
        chk("rd_T1_hready", 64'(bus.Hreadyout), 64'(0));
        chk("rd_T1_pselx", 64'(bus.Pselx), 64'(0));
        cyc(); #1;
        chk("rd_T2_pselx", 64'(bus.Pselx), 64'(3'b001));
        chk("rd_T2_penable", 64'(bus.Penable), 64'(0));
        chk("rd_T2_paddr", 64'(bus.Paddr), 64'(32'h8000_0010));
        chk("rd_T2_pwrite", 64'(bus.Pwrite), 64'(0));
        chk("rd_T2_hready", 64'(bus.Hreadyout), 64'(0));
        cyc(); #1;
        chk("rd_T3_pselx", 64'(bus.Pselx), 64'(3'b001));
        chk("rd_T3_penable", 64'(bus.Penable), 64'(1));
        chk("rd_T3_hready", 64'(bus.Hreadyout), 64'(1));
        cyc(); #1;
        chk("rd_T4_pselx", 64'(bus.Pselx), 64'(0));
        chk("rd_T4_penable", 64'(bus.Penable), 64'(0));
        chk("rd_T4_paddr_hold", 64'(bus.Paddr), 64'(32'h8000_0010));

        // Single write
        cyc(); issue(1'b1, 3'b010, 32'h8400_0004, 32'hDEAD_BEEF); #1;
        chk("wr_T0_hready", 64'(bus.Hreadyout), 64'(1));
        cyc(); idle_in(); hwdata = 32'hDEAD_BEEF; #1;
        chk("wr_T1_hready", 64'(bus.Hreadyout), 64'(0));
        cyc(); hwdata = '0; #1;
        chk("wr_T2_pselx", 64'(bus.Pselx), 64'(0));
        chk("wr_T2_hready", 64'(bus.Hreadyout), 64'(0));
        cyc(); #1;
        chk("wr_T3_pselx", 64'(bus.Pselx), 64'(3'b010));
        chk("wr_T3_penable", 64'(bus.Penable), 64'(0));
        chk("wr_T3_pwrite", 64'(bus.Pwrite), 64'(1));
        chk("wr_T3_paddr", 64'(bus.Paddr), 64'(32'h8400_0004));
        chk("wr_T3_pwdata", 64'(bus.Pwdata), 64'(32'hDEAD_BEEF));
        chk("wr_T3_hready", 64'(bus.Hreadyout), 64'(0));
        cyc(); #1;
        chk("wr_T4_pselx", 64'(bus.Pselx), 64'(3'b010));
        chk("wr_T4_penable", 64'(bus.Penable), 64'(1));
        chk("wr_T4_hready", 64'(bus.Hreadyout), 64'(1));
        cyc(); #1;
        chk("wr_T5_pselx", 64'(bus.Pselx), 64'(0));

        // Read with three wait states
        cyc(); issue(1'b0, 3'b100, 32'h8800_0000, '0);
        cyc(); idle_in();
        cyc(); #1;
        chk("ws_setup_pselx", 64'(bus.Pselx), 64'(3'b100));
        for (int i = 0; i < 3; i++) begin
            cyc(); bus.Pready = 1'b0; #1;
            chk("ws_wait_pselx", 64'(bus.Pselx), 64'(3'b100));
            chk("ws_wait_penable", 64'(bus.Penable), 64'(1));
            chk("ws_wait_hready", 64'(bus.Hreadyout), 64'(0));
        end
        cyc(); bus.Pready = 1'b1; #1;
        chk("ws_done_penable", 64'(bus.Penable), 64'(1));
        chk("ws_done_hready", 64'(bus.Hreadyout), 64'(1));
        cyc(); #1;
        chk("ws_after_pselx", 64'(bus.Pselx), 64'(0));
        chk("ws_after_penable", 64'(bus.Penable), 64'(0));

        // Back-to-back write then read
        cyc(); issue(1'b1, 3'b001, 32'h8000_0000, 32'h1234_5678);
        cyc(); idle_in(); hwdata = 32'h1234_5678;
        cyc(); hwdata = '0;
        cyc(); #1;
        chk("b2b_wsetup_pselx", 64'(bus.Pselx), 64'(3'b001));
        chk("b2b_wsetup_pwrite", 64'(bus.Pwrite), 64'(1));
        cyc(); issue(1'b0, 3'b010, 32'h8400_0008, '0); #1;
        chk("b2b_waccess_penable", 64'(bus.Penable), 64'(1));
        chk("b2b_waccess_hready", 64'(bus.Hreadyout), 64'(1));
        cyc(); idle_in(); #1;
        chk("b2b_rwait_pselx", 64'(bus.Pselx), 64'(0));
        chk("b2b_rwait_penable", 64'(bus.Penable), 64'(0));
        chk("b2b_rwait_hready", 64'(bus.Hreadyout), 64'(0));
        cyc(); #1;
        chk("b2b_rsetup_pselx", 64'(bus.Pselx), 64'(3'b010));
        chk("b2b_rsetup_paddr", 64'(bus.Paddr), 64'(32'h8400_0008));
        chk("b2b_rsetup_pwrite", 64'(bus.Pwrite), 64'(0));
        cyc(); #1;
        chk("b2b_raccess_penable", 64'(bus.Penable), 64'(1));
        chk("b2b_raccess_hready", 64'(bus.Hreadyout), 64'(1));

        // valid held through RWAIT/SETUP must be ignored
        cyc(); idle_in();
        cyc(); issue(1'b0, 3'b001, 32'h8000_0020, '0);
        cyc(); bus.Hwritereg = 1'b1; bus.tempselx = 3'b100; haddr = 32'h8FFF_FFF0; #1;
        chk("ign_r_T1_hready", 64'(bus.Hreadyout), 64'(0));
        cyc(); #1;
        chk("ign_r_T2_pselx", 64'(bus.Pselx), 64'(3'b001));
        chk("ign_r_T2_paddr", 64'(bus.Paddr), 64'(32'h8000_0020));
        cyc(); idle_in(); #1;
        chk("ign_r_T3_penable", 64'(bus.Penable), 64'(1));
        cyc(); #1;
        chk("ign_r_T4_pselx", 64'(bus.Pselx), 64'(0));
        cyc(); #1;
        chk("ign_r_T5_pselx", 64'(bus.Pselx), 64'(0));
        chk("ign_r_T5_hready", 64'(bus.Hreadyout), 64'(1));

        // valid held through WWAIT1/WWAIT2/SETUP must be ignored
        cyc(); issue(1'b1, 3'b010, 32'h8400_0010, 32'hA5A5_5A5A);
        cyc(); hwdata = 32'hA5A5_5A5A;
        bus.Hwritereg = 1'b0; bus.tempselx = 3'b001; haddr = 32'h8000_00FC;
        cyc(); hwdata = 32'h1111_1111;
        cyc(); #1;
        chk("ign_w_T3_pselx", 64'(bus.Pselx), 64'(3'b010));
        chk("ign_w_T3_paddr", 64'(bus.Paddr), 64'(32'h8400_0010));
        chk("ign_w_T3_pwdata", 64'(bus.Pwdata), 64'(32'hA5A5_5A5A));
        cyc(); idle_in(); hwdata = '0; #1;
        chk("ign_w_T4_penable", 64'(bus.Penable), 64'(1));
        cyc(); #1;
        chk("ign_w_T5_pselx", 64'(bus.Pselx), 64'(0));
        cyc(); #1;
        chk("ign_w_T6_pselx", 64'(bus.Pselx), 64'(0));
        chk("ign_w_T6_hready", 64'(bus.Hreadyout), 64'(1));
        chk("sb_drained", 64'(exp_q.size()), 64'(0));

        // Reset during a stalled ACCESS
        cyc(); issue(1'b0, 3'b010, 32'h8000_0030, '0);
        cyc(); idle_in();
        cyc();
        cyc(); bus.Pready = 1'b0; #1;
        chk("rstacc_penable", 64'(bus.Penable), 64'(1));
        chk("rstacc_hready", 64'(bus.Hreadyout), 64'(0));
        Hresetn = 1'b0;
        #1;
        chk("rstacc_pselx_async", 64'(bus.Pselx), 64'(0));
        chk("rstacc_penable_async", 64'(bus.Penable), 64'(0));
        chk("rstacc_hready_async", 64'(bus.Hreadyout), 64'(1));
        exp_q.delete();
        cyc(); Hresetn = 1'b1; #1;
        cyc(); #1;
        // Pready still low: Hreadyout=1 only if the FSM is back in IDLE
        chk("rstacc_idle_hready", 64'(bus.Hreadyout), 64'(1));
        chk("rstacc_idle_pselx", 64'(bus.Pselx), 64'(0));

        // Recovery transfer after reset
        cyc(); bus.Pready = 1'b1; issue(1'b0, 3'b100, 32'h8800_0040, '0);
        cyc(); idle_in();
        cyc(); #1;
        chk("rec_setup_paddr", 64'(bus.Paddr), 64'(32'h8800_0040));
        cyc();
        cyc(); #1;
        chk("rec_end_pselx", 64'(bus.Pselx), 64'(0));
        chk("sb_final_drained", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

endmodule
